// File: rtl/mips_cpu_pc_seq_if.sv
// Fetch-control bundle between decode/branch resolution (master) and the PC sequencer (slave).
interface mips_cpu_pc_seq_if #(
    parameter int WIDTH = 32
);
    logic             stall;
    logic             redirect_valid;
    logic [WIDTH-1:0] redirect_target;
    logic             exc_valid;
    logic [WIDTH-1:0] pc_out;
    logic [WIDTH-1:0] npc_out;
    logic             in_delay_slot;
    logic             active;
    logic             fault;

    modport master (
        output stall, redirect_valid, redirect_target, exc_valid,
        input  pc_out, npc_out, in_delay_slot, active, fault
    );

    modport slave (
        input  stall, redirect_valid, redirect_target, exc_valid,
        output pc_out, npc_out, in_delay_slot, active, fault
    );
endinterface

// File: rtl/mips_cpu_pc_seq.sv
// PC/NPC sequencer for the MIPS fetch stage: delay slot, stall hold,
// exception vectoring and halt when fetch reaches address zero.
module mips_cpu_pc_seq #(
    parameter int               WIDTH        = 32,
    parameter logic [WIDTH-1:0] RESET_VECTOR = 32'hBFC00000,
    parameter logic [WIDTH-1:0] EXC_VECTOR   = 32'hBFC00380,
    parameter int               INSTR_BYTES  = 4
) (
    input  logic                clk,
    input  logic                rst,
    mips_cpu_pc_seq_if.slave    bus
);
    localparam logic [WIDTH-1:0] STEP = WIDTH'(INSTR_BYTES);
    localparam logic [WIDTH-1:0] ZERO = {WIDTH{1'b0}};

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_DELAY  = 2'd1,
        ST_HALTED = 2'd2
    } state_t;

    function automatic logic is_aligned(input logic [WIDTH-1:0] addr);
        return (addr[1:0] == 2'b00);
    endfunction

    state_t           state_q, state_d;
    logic [WIDTH-1:0] pc_q, pc_d;
    logic [WIDTH-1:0] npc_q, npc_d;
    logic             ds_q, ds_d;
    logic             active_q, active_d;
    logic             fault_q, fault_d;
    logic             load_s;

    // Next-state and output logic; priority HALTED > exception > stall > redirect > sequential.
    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        npc_d    = npc_q;
        ds_d     = ds_q;
        active_d = active_q;
        fault_d  = fault_q;
        load_s   = 1'b0;
        case (state_q)
            ST_HALTED: begin
                active_d = 1'b0;
            end
            ST_RUN, ST_DELAY: begin
                if (bus.exc_valid) begin
                    pc_d    = EXC_VECTOR;
                    npc_d   = EXC_VECTOR + STEP;
                    state_d = ST_RUN;
                    ds_d    = 1'b0;
                    load_s  = 1'b1;
                end else if (bus.stall) begin
                    load_s = 1'b0;
                end else if (state_q == ST_DELAY) begin
                    // A branch sitting in the delay slot is not architecturally legal.
                    if (bus.redirect_valid) begin
                        fault_d = 1'b1;
                    end else begin
                        fault_d = fault_q;
                    end
                    pc_d    = npc_q;
                    npc_d   = npc_q + STEP;
                    state_d = ST_RUN;
                    ds_d    = 1'b0;
                    load_s  = 1'b1;
                end else if (bus.redirect_valid && is_aligned(bus.redirect_target)) begin
                    pc_d    = npc_q;
                    npc_d   = bus.redirect_target;
                    state_d = ST_DELAY;
                    ds_d    = 1'b1;
                    load_s  = 1'b1;
                end else begin
                    if (bus.redirect_valid) begin
                        fault_d = 1'b1;
                    end else begin
                        fault_d = fault_q;
                    end
                    pc_d   = npc_q;
                    npc_d  = npc_q + STEP;
                    load_s = 1'b1;
                end
            end
            default: begin
                state_d  = ST_HALTED;
                active_d = 1'b0;
                fault_d  = 1'b1;
            end
        endcase

        // Fetching address zero stops the core on the very edge that loads it.
        if (load_s && (pc_d == ZERO)) begin
            state_d  = ST_HALTED;
            active_d = 1'b0;
        end else begin
            active_d = active_d;
        end
    end

    // State and registered outputs, asynchronously reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_RUN;
            pc_q     <= RESET_VECTOR;
            npc_q    <= RESET_VECTOR + STEP;
            ds_q     <= 1'b0;
            active_q <= 1'b1;
            fault_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            npc_q    <= npc_d;
            ds_q     <= ds_d;
            active_q <= active_d;
            fault_q  <= fault_d;
        end
    end

    assign bus.pc_out        = pc_q;
    assign bus.npc_out       = npc_q;
    assign bus.in_delay_slot = ds_q;
    assign bus.active        = active_q;
    assign bus.fault         = fault_q;
endmodule

// File: tb/tb_mips_cpu_pc_seq.sv
// Scoreboard bench: stimulus pushes model predictions, a monitor pops and compares after each edge.
module tb_mips_cpu_pc_seq;
    localparam logic [31:0] RV  = 32'hBFC00000;
    localparam logic [31:0] EV  = 32'hBFC00380;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] npc;
        logic        ds;
        logic        act;
        logic        flt;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_chk  = 0;
    int   n_pass = 0;
    exp_t exp_q[$];

    // Architectural model: current fetch, following fetch, pending delay slot, halted, sticky fault.
    logic [31:0] m_pc, m_npc;
    logic        m_slot, m_halt, m_fault;

    mips_cpu_pc_seq_if #(.WIDTH(32)) bus ();

    mips_cpu_pc_seq dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] got, input logic [31:0] want);
        n_chk++;
        if (got === want) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h", nm, got, want);
        end
    endtask

    task automatic model_reset();
        m_pc = RV; m_npc = RV + 32'd4; m_slot = 1'b0; m_halt = 1'b0; m_fault = 1'b0;
    endtask

    // Apply one cycle of inputs: called at a negedge, returns at the following negedge.
    task automatic drive(input logic st, input logic rv, input logic [31:0] rt, input logic ev);
        exp_t e;
        logic loaded;
        bus.stall = st; bus.redirect_valid = rv; bus.redirect_target = rt; bus.exc_valid = ev;
        loaded = 1'b0;
        if (m_halt) begin
            loaded = 1'b0;
        end else if (ev) begin
            m_pc = EV; m_npc = EV + 32'd4; m_slot = 1'b0; loaded = 1'b1;
        end else if (st) begin
            loaded = 1'b0;
        end else if (m_slot) begin
            if (rv) m_fault = 1'b1;
            m_pc = m_npc; m_npc = m_npc + 32'd4; m_slot = 1'b0; loaded = 1'b1;
        end else if (rv && (rt % 4 == 0)) begin
            m_pc = m_npc; m_npc = rt; m_slot = 1'b1; loaded = 1'b1;
        end else begin
            if (rv) m_fault = 1'b1;
            m_pc = m_npc; m_npc = m_npc + 32'd4; loaded = 1'b1;
        end
        if (loaded && m_pc == 32'd0) m_halt = 1'b1;
        e.pc = m_pc; e.npc = m_npc; e.ds = m_slot; e.act = ~m_halt; e.flt = m_fault;
        exp_q.push_back(e);
        @(negedge clk);
    endtask

    task automatic seq(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 32'd0, 1'b0);
    endtask

    // Asynchronous reset between edges; outputs must change before the next posedge.
    task automatic do_reset();
        bus.stall = 1'b0; bus.redirect_valid = 1'b0; bus.redirect_target = 32'd0; bus.exc_valid = 1'b0;
        #2 rst = 1'b1;
        #1;
        check("rst_pc",  bus.pc_out, RV);
        check("rst_npc", bus.npc_out, RV + 32'd4);
        check("rst_ds",  {31'd0, bus.in_delay_slot}, 32'd0);
        check("rst_act", {31'd0, bus.active}, 32'd1);
        check("rst_flt", {31'd0, bus.fault}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
    endtask

    // Monitor: every edge that has a prediction queued is compared field by field.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("pc",  bus.pc_out, e.pc);
                check("npc", bus.npc_out, e.npc);
                check("ds",  {31'd0, bus.in_delay_slot}, {31'd0, e.ds});
                check("act", {31'd0, bus.active}, {31'd0, e.act});
                check("flt", {31'd0, bus.fault}, {31'd0, e.flt});
            end
        end
    end

    initial begin
        int r;
        logic [31:0] tgt;
        bus.stall = 1'b0; bus.redirect_valid = 1'b0; bus.redirect_target = 32'd0; bus.exc_valid = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        do_reset();

        // Free run, then branch with delay slot.
        seq(2);
        drive(1'b0, 1'b1, 32'hBFC00100, 1'b0);
        seq(2);
        // Stall while in the delay slot, then release.
        do_reset();
        seq(2);
        drive(1'b0, 1'b1, 32'hBFC00100, 1'b0);
        drive(1'b1, 1'b1, 32'hBFC00500, 1'b0);
        drive(1'b1, 1'b0, 32'd0, 1'b0);
        seq(2);
        // Exception under stall inside a delay slot.
        drive(1'b0, 1'b1, 32'hBFC00200, 1'b0);
        drive(1'b1, 1'b0, 32'd0, 1'b1);
        seq(1);
        // Jump to zero halts after the delay slot; halted core ignores everything.
        do_reset();
        seq(4);
        drive(1'b0, 1'b1, 32'h00000000, 1'b0);
        seq(1);
        drive(1'b0, 1'b1, 32'hBFC00040, 1'b0);
        drive(1'b1, 1'b0, 32'd0, 1'b1);
        drive(1'b0, 1'b0, 32'd0, 1'b1);
        do_reset();
        // Misaligned target and branch inside a delay slot.
        drive(1'b0, 1'b1, 32'hBFC00102, 1'b0);
        seq(1);
        drive(1'b0, 1'b1, 32'hBFC00200, 1'b0);
        drive(1'b0, 1'b1, 32'hBFC00300, 1'b0);
        seq(1);
        // Reset arriving while a delay slot is pending.
        drive(1'b0, 1'b1, 32'hBFC00400, 1'b0);
        do_reset();
        // Wrap of the address space reaches zero and halts.
        drive(1'b0, 1'b1, 32'hFFFFFFF8, 1'b0);
        seq(4);
        do_reset();

        // Randomised traffic.
        for (int i = 0; i < 400; i++) begin
            if (m_halt && ($urandom % 3 == 0)) begin
                do_reset();
            end else begin
                r = $urandom % 20;
                if (r == 0)      tgt = 32'd0;
                else if (r == 1) tgt = 32'hBFC00000 | ($urandom & 32'h0000FFFC) | 32'd1 + ($urandom % 3);
                else             tgt = 32'hBFC00000 | ($urandom & 32'h0000FFFC);
                drive(($urandom % 4) == 0, ($urandom % 3) == 0, tgt, ($urandom % 16) == 0);
            end
        end

        for (int w = 0; w < 10 && exp_q.size() > 0; w++) @(negedge clk);
        if (exp_q.size() > 0) begin
            n_chk++;
            $display("FAIL drain: got %0d pending expected 0", exp_q.size());
        end
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
